// File: rtl/sys_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : sys_ctrl
// Description : Command sequencer from UART RX bytes to register file / ALU,
//               returning results through the TX FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
module sys_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4,
    parameter int FUN_WIDTH  = 4
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic [DATA_WIDTH-1:0]   RX_P_DATA,
    input  logic                    RX_D_VLD,
    input  logic [DATA_WIDTH-1:0]   RdData,
    input  logic                    RdData_Valid,
    input  logic [2*DATA_WIDTH-1:0] ALU_OUT,
    input  logic                    ALU_OUT_VLD,
    input  logic                    FIFO_FULL,
    output logic [ADDR_WIDTH-1:0]   Address,
    output logic                    WrEn,
    output logic                    RdEn,
    output logic [DATA_WIDTH-1:0]   WrData,
    output logic                    ALU_EN,
    output logic [FUN_WIDTH-1:0]    ALU_FUN,
    output logic                    CLK_GATE_EN,
    output logic [DATA_WIDTH-1:0]   TX_P_DATA,
    output logic                    TX_D_VLD
);

    localparam logic [DATA_WIDTH-1:0] C_CMD_RF_WR  = DATA_WIDTH'(8'hAA);
    localparam logic [DATA_WIDTH-1:0] C_CMD_RF_RD  = DATA_WIDTH'(8'hBB);
    localparam logic [DATA_WIDTH-1:0] C_CMD_ALU_OP = DATA_WIDTH'(8'hCC);
    localparam logic [DATA_WIDTH-1:0] C_CMD_ALU_NP = DATA_WIDTH'(8'hDD);

    localparam logic [3:0] S_IDLE     = 4'd0;
    localparam logic [3:0] S_WR_ADDR  = 4'd1;
    localparam logic [3:0] S_WR_DATA  = 4'd2;
    localparam logic [3:0] S_RD_ADDR  = 4'd3;
    localparam logic [3:0] S_RD_WAIT  = 4'd4;
    localparam logic [3:0] S_TX_SEND  = 4'd5;
    localparam logic [3:0] S_ALU_A    = 4'd6;
    localparam logic [3:0] S_ALU_B    = 4'd7;
    localparam logic [3:0] S_ALU_FUN  = 4'd8;
    localparam logic [3:0] S_ALU_WAIT = 4'd9;
    localparam logic [3:0] S_TX_LO    = 4'd10;
    localparam logic [3:0] S_TX_HI    = 4'd11;

    logic [3:0]              r_state;
    logic [DATA_WIDTH-1:0]   r_rd_data;
    logic [2*DATA_WIDTH-1:0] r_alu_res;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_state     <= S_IDLE;
            r_rd_data   <= '0;
            r_alu_res   <= '0;
            Address     <= '0;
            WrEn        <= 1'b0;
            RdEn        <= 1'b0;
            WrData      <= '0;
            ALU_EN      <= 1'b0;
            ALU_FUN     <= '0;
            CLK_GATE_EN <= 1'b0;
            TX_P_DATA   <= '0;
            TX_D_VLD    <= 1'b0;
        end else begin
            // Strobes default low so every pulse lasts exactly one cycle
            WrEn     <= 1'b0;
            RdEn     <= 1'b0;
            ALU_EN   <= 1'b0;
            TX_D_VLD <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (RX_D_VLD) begin
                        case (RX_P_DATA)
                            C_CMD_RF_WR:  r_state <= S_WR_ADDR;
                            C_CMD_RF_RD:  r_state <= S_RD_ADDR;
                            C_CMD_ALU_OP: r_state <= S_ALU_A;
                            C_CMD_ALU_NP: begin
                                r_state     <= S_ALU_FUN;
                                CLK_GATE_EN <= 1'b1;
                            end
                            default:      r_state <= S_IDLE;
                        endcase
                    end
                end
                S_WR_ADDR: begin
                    if (RX_D_VLD) begin
                        Address <= RX_P_DATA[ADDR_WIDTH-1:0];
                        r_state <= S_WR_DATA;
                    end
                end
                S_WR_DATA: begin
                    if (RX_D_VLD) begin
                        WrData  <= RX_P_DATA;
                        WrEn    <= 1'b1;
                        r_state <= S_IDLE;
                    end
                end
                S_RD_ADDR: begin
                    if (RX_D_VLD) begin
                        Address <= RX_P_DATA[ADDR_WIDTH-1:0];
                        RdEn    <= 1'b1;
                        r_state <= S_RD_WAIT;
                    end
                end
                S_RD_WAIT: begin
                    if (RdData_Valid) begin
                        r_rd_data <= RdData;
                        r_state   <= S_TX_SEND;
                    end
                end
                S_TX_SEND: begin
                    if (!FIFO_FULL) begin
                        TX_P_DATA <= r_rd_data;
                        TX_D_VLD  <= 1'b1;
                        r_state   <= S_IDLE;
                    end
                end
                // Operands land in fixed register slots 0 and 1 for the ALU
                S_ALU_A: begin
                    if (RX_D_VLD) begin
                        Address <= '0;
                        WrData  <= RX_P_DATA;
                        WrEn    <= 1'b1;
                        r_state <= S_ALU_B;
                    end
                end
                S_ALU_B: begin
                    if (RX_D_VLD) begin
                        Address     <= ADDR_WIDTH'(1);
                        WrData      <= RX_P_DATA;
                        WrEn        <= 1'b1;
                        CLK_GATE_EN <= 1'b1;
                        r_state     <= S_ALU_FUN;
                    end
                end
                S_ALU_FUN: begin
                    if (RX_D_VLD) begin
                        ALU_FUN <= RX_P_DATA[FUN_WIDTH-1:0];
                        ALU_EN  <= 1'b1;
                        r_state <= S_ALU_WAIT;
                    end
                end
                S_ALU_WAIT: begin
                    if (ALU_OUT_VLD) begin
                        r_alu_res   <= ALU_OUT;
                        CLK_GATE_EN <= 1'b0;
                        r_state     <= S_TX_LO;
                    end
                end
                S_TX_LO: begin
                    if (!FIFO_FULL) begin
                        TX_P_DATA <= r_alu_res[DATA_WIDTH-1:0];
                        TX_D_VLD  <= 1'b1;
                        r_state   <= S_TX_HI;
                    end
                end
                S_TX_HI: begin
                    if (!FIFO_FULL) begin
                        TX_P_DATA <= r_alu_res[2*DATA_WIDTH-1:DATA_WIDTH];
                        TX_D_VLD  <= 1'b1;
                        r_state   <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sys_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_sys_ctrl
// Description : Self-checking bench for sys_ctrl using a frame-level model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sys_ctrl;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic [7:0]  RX_P_DATA = '0;
    logic        RX_D_VLD = 1'b0;
    logic [7:0]  RdData = '0;
    logic        RdData_Valid = 1'b0;
    logic [15:0] ALU_OUT = '0;
    logic        ALU_OUT_VLD = 1'b0;
    logic        FIFO_FULL = 1'b0;
    logic [3:0]  Address;
    logic        WrEn;
    logic        RdEn;
    logic [7:0]  WrData;
    logic        ALU_EN;
    logic [3:0]  ALU_FUN;
    logic        CLK_GATE_EN;
    logic [7:0]  TX_P_DATA;
    logic        TX_D_VLD;

    always #5 CLK = ~CLK;

    sys_ctrl #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .FUN_WIDTH(4)) dut (
        .CLK(CLK), .RST(RST), .RX_P_DATA(RX_P_DATA), .RX_D_VLD(RX_D_VLD),
        .RdData(RdData), .RdData_Valid(RdData_Valid), .ALU_OUT(ALU_OUT),
        .ALU_OUT_VLD(ALU_OUT_VLD), .FIFO_FULL(FIFO_FULL), .Address(Address),
        .WrEn(WrEn), .RdEn(RdEn), .WrData(WrData), .ALU_EN(ALU_EN),
        .ALU_FUN(ALU_FUN), .CLK_GATE_EN(CLK_GATE_EN), .TX_P_DATA(TX_P_DATA),
        .TX_D_VLD(TX_D_VLD)
    );

    int          n_vec = 0;
    int          n_err = 0;
    logic [11:0] got_wr[$], exp_wr[$];
    logic [3:0]  got_rd[$], exp_rd[$];
    logic [3:0]  got_fun[$], exp_fun[$];
    logic [7:0]  got_tx[$], exp_tx[$];
    int          full_mode = 0;
    int          full_hold = 0;
    logic        prev_full = 1'b0;
    logic        nf;
    logic        alu_win = 1'b0;
    logic [3:0]  last_fun = '0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Monitor: records strobed transactions and drives the FIFO full flag
    always @(negedge CLK) begin
        if (RST) begin
            if (WrEn) got_wr.push_back({Address, WrData});
            if (RdEn) got_rd.push_back(Address);
            if (ALU_EN) begin
                got_fun.push_back(ALU_FUN);
                check("gate_at_alu_en", 32'(CLK_GATE_EN), 32'd1);
            end
            if (TX_D_VLD) begin
                got_tx.push_back(TX_P_DATA);
                check("tx_while_full", 32'(prev_full), 32'd0);
            end
            if (CLK_GATE_EN && !alu_win) check("gate_outside_alu", 32'(CLK_GATE_EN), 32'd0);
        end
        if (full_mode == 1) nf = ($urandom_range(0, 2) == 0);
        else if (full_mode == 2 && TX_D_VLD && got_tx.size() == 1) begin
            nf = 1'b1;
            full_hold = 4;
        end else if (full_hold > 0) begin
            nf = 1'b1;
            full_hold--;
        end else nf = 1'b0;
        FIFO_FULL = nf;
        prev_full = nf;
    end

    task automatic tick();
        @(posedge CLK);
        #2;
    endtask

    function automatic int rgap();
        return int'($urandom_range(0, 2));
    endfunction

    task automatic send_byte(input logic [7:0] b, input int gap);
        RX_P_DATA = b;
        RX_D_VLD  = 1'b1;
        tick();
        RX_D_VLD  = 1'b0;
        RX_P_DATA = 8'($urandom);
        repeat (gap) tick();
    endtask

    task automatic clear_q();
        got_wr.delete(); got_rd.delete(); got_fun.delete(); got_tx.delete();
        exp_wr.delete(); exp_rd.delete(); exp_fun.delete(); exp_tx.delete();
    endtask

    task automatic wait_tx(input int n);
        for (int i = 0; i < 300 && got_tx.size() < n; i++) tick();
    endtask

    task automatic compare_frame(input string tag);
        repeat (3) tick();
        check({tag, "_nwr"}, 32'(got_wr.size()), 32'(exp_wr.size()));
        for (int i = 0; i < exp_wr.size() && i < got_wr.size(); i++)
            check($sformatf("%s_wr%0d", tag, i), 32'(got_wr[i]), 32'(exp_wr[i]));
        check({tag, "_nrd"}, 32'(got_rd.size()), 32'(exp_rd.size()));
        for (int i = 0; i < exp_rd.size() && i < got_rd.size(); i++)
            check($sformatf("%s_rd%0d", tag, i), 32'(got_rd[i]), 32'(exp_rd[i]));
        check({tag, "_nfun"}, 32'(got_fun.size()), 32'(exp_fun.size()));
        for (int i = 0; i < exp_fun.size() && i < got_fun.size(); i++)
            check($sformatf("%s_fun%0d", tag, i), 32'(got_fun[i]), 32'(exp_fun[i]));
        check({tag, "_ntx"}, 32'(got_tx.size()), 32'(exp_tx.size()));
        for (int i = 0; i < exp_tx.size() && i < got_tx.size(); i++)
            check($sformatf("%s_tx%0d", tag, i), 32'(got_tx[i]), 32'(exp_tx[i]));
        check({tag, "_gate_end"}, 32'(CLK_GATE_EN), 32'd0);
        check({tag, "_fun_hold"}, 32'(ALU_FUN), 32'(last_fun));
    endtask

    task automatic do_wr(input logic [3:0] a, input logic [7:0] d, input string tag);
        clear_q();
        exp_wr.push_back({a, d});
        send_byte(8'hAA, rgap());
        send_byte({4'($urandom), a}, rgap());
        send_byte(d, 0);
        check({tag, "_wren_now"}, 32'({WrEn, Address, WrData}), 32'({1'b1, a, d}));
        compare_frame(tag);
    endtask

    task automatic do_rd(input logic [3:0] a, input logic [7:0] val, input int lat,
                         input bit inject, input string tag);
        clear_q();
        exp_rd.push_back(a);
        exp_tx.push_back(val);
        send_byte(8'hBB, rgap());
        send_byte({4'($urandom), a}, 0);
        check({tag, "_rden_now"}, 32'({RdEn, Address}), 32'({1'b1, a}));
        // A new command byte during the read wait must be ignored
        if (inject && lat >= 2) begin
            send_byte(8'hAA, 0);
            repeat (lat - 1) tick();
        end else repeat (lat) tick();
        RdData = val;
        RdData_Valid = 1'b1;
        tick();
        RdData_Valid = 1'b0;
        RdData = 8'($urandom);
        wait_tx(1);
        compare_frame(tag);
    endtask

    task automatic do_alu(input bit with_ops, input logic [7:0] a, input logic [7:0] b,
                          input logic [3:0] fun, input logic [15:0] res, input int lat,
                          input bit hold_full, input string tag);
        clear_q();
        if (with_ops) begin
            exp_wr.push_back({4'd0, a});
            exp_wr.push_back({4'd1, b});
        end
        exp_fun.push_back(fun);
        exp_tx.push_back(res[7:0]);
        exp_tx.push_back(res[15:8]);
        last_fun = fun;
        if (with_ops) begin
            send_byte(8'hCC, rgap());
            send_byte(a, rgap());
            alu_win = 1'b1;
            send_byte(b, 0);
            check({tag, "_opb_now"}, 32'({WrEn, Address, WrData}), 32'({1'b1, 4'd1, b}));
        end else begin
            alu_win = 1'b1;
            send_byte(8'hDD, 0);
        end
        check({tag, "_gate_on"}, 32'(CLK_GATE_EN), 32'd1);
        repeat (rgap()) tick();
        send_byte({4'($urandom), fun}, 0);
        check({tag, "_aluen_now"}, 32'({ALU_EN, ALU_FUN}), 32'({1'b1, fun}));
        if (hold_full) full_mode = 2;
        repeat (lat) tick();
        check({tag, "_gate_wait"}, 32'(CLK_GATE_EN), 32'd1);
        ALU_OUT = res;
        ALU_OUT_VLD = 1'b1;
        tick();
        ALU_OUT_VLD = 1'b0;
        ALU_OUT = 16'($urandom);
        check({tag, "_gate_off"}, 32'(CLK_GATE_EN), 32'd0);
        alu_win = 1'b0;
        if (hold_full) begin
            wait_tx(1);
            repeat (3) tick();
            check({tag, "_held_by_full"}, 32'(got_tx.size()), 32'd1);
        end
        wait_tx(2);
        compare_frame(tag);
        if (hold_full) full_mode = 0;
    endtask

    initial begin
        logic [7:0] jb;
        repeat (3) tick();
        check("reset_outputs", 32'({Address, WrEn, RdEn, WrData, ALU_EN, ALU_FUN,
                                    CLK_GATE_EN, TX_P_DATA, TX_D_VLD}), 32'd0);
        RST = 1'b1;
        tick();

        do_wr(4'h5, 8'h3C, "wr_dir");
        do_rd(4'h5, 8'h3C, 3, 1'b0, "rd_dir");
        do_alu(1'b1, 8'h10, 8'h20, 4'h0, 16'h0030, 4, 1'b0, "alu_dir");
        do_alu(1'b0, 8'h00, 8'h00, 4'h2, 16'hA55A, 2, 1'b1, "nop_full");

        clear_q();
        send_byte(8'h55, 2);
        compare_frame("junk");

        // Reset arriving after the address byte of a write
        clear_q();
        send_byte(8'hAA, 0);
        send_byte(8'h05, 1);
        RST = 1'b0;
        #1;
        check("rst_mid_outputs", 32'({Address, WrEn, RdEn, WrData, ALU_EN, ALU_FUN,
                                      CLK_GATE_EN, TX_P_DATA, TX_D_VLD}), 32'd0);
        last_fun = '0;
        tick();
        RST = 1'b1;
        tick();
        send_byte(8'h3C, 1);
        compare_frame("rst_idle");
        do_wr(4'h5, 8'h3C, "wr_after_rst");

        full_mode = 1;
        for (int f = 0; f < 40; f++) begin
            case ($urandom_range(0, 4))
                0: do_wr(4'($urandom), 8'($urandom), $sformatf("r%0d_wr", f));
                1: do_rd(4'($urandom), 8'($urandom), int'($urandom_range(1, 5)),
                         1'($urandom), $sformatf("r%0d_rd", f));
                2: do_alu(1'b1, 8'($urandom), 8'($urandom), 4'($urandom), 16'($urandom),
                          int'($urandom_range(0, 5)), 1'b0, $sformatf("r%0d_alu", f));
                3: do_alu(1'b0, 8'h00, 8'h00, 4'($urandom), 16'($urandom),
                          int'($urandom_range(0, 5)), 1'b0, $sformatf("r%0d_nop", f));
                default: begin
                    clear_q();
                    jb = 8'($urandom);
                    while (jb == 8'hAA || jb == 8'hBB || jb == 8'hCC || jb == 8'hDD)
                        jb = 8'($urandom);
                    send_byte(jb, 1);
                    compare_frame($sformatf("r%0d_junk", f));
                end
            endcase
        end
        full_mode = 0;
        repeat (3) tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
